// File: rtl/fp_issue_pkg.sv
// fp_issue_pkg: Cop1 funct codes, FPU op codes, slot states,
// and the funct -> {legal, op, latency} decoder.
package fp_issue_pkg;

  localparam logic [5:0] F_ADD    = 6'h00;
  localparam logic [5:0] F_SUB    = 6'h01;
  localparam logic [5:0] F_MUL    = 6'h02;
  localparam logic [5:0] F_DIV    = 6'h03;
  localparam logic [5:0] F_SQRT   = 6'h04;
  localparam logic [5:0] F_ABS    = 6'h05;
  localparam logic [5:0] F_NEG    = 6'h07;
  localparam logic [5:0] F_ROUNDW = 6'h0C;
  localparam logic [5:0] F_CEILW  = 6'h0E;
  localparam logic [5:0] F_FLOORW = 6'h0F;
  localparam logic [5:0] F_CVTSW  = 6'h20;
  localparam logic [5:0] F_CVTWS  = 6'h24;
  localparam logic [5:0] F_CEQ    = 6'h32;
  localparam logic [5:0] F_CLT    = 6'h3C;
  localparam logic [5:0] F_CLE    = 6'h3E;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DIV    = 4'd3;
  localparam logic [3:0] OP_SQRT   = 4'd4;
  localparam logic [3:0] OP_ABS    = 4'd5;
  localparam logic [3:0] OP_NEG    = 4'd6;
  localparam logic [3:0] OP_CEQ    = 4'd7;
  localparam logic [3:0] OP_CLT    = 4'd8;
  localparam logic [3:0] OP_CLE    = 4'd9;
  localparam logic [3:0] OP_CVTSW  = 4'd10;
  localparam logic [3:0] OP_CVTWS  = 4'd11;
  localparam logic [3:0] OP_ROUNDW = 4'd12;
  localparam logic [3:0] OP_CEILW  = 4'd13;
  localparam logic [3:0] OP_FLOORW = 4'd14;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    SLOT_IDLE = ST_IDLE,
    SLOT_BUSY = ST_BUSY,
    SLOT_DONE = ST_DONE
  } slot_state_e;

  typedef struct packed {
    logic       legal;
    logic [3:0] op;
    logic [4:0] lat;
  } fp_dec_t;

  function automatic fp_dec_t funct_to_lat(
    input logic [5:0] funct
  );
    fp_dec_t d;
    d = '0;
    d.legal = 1'b1;
    case (funct)
      F_ADD:    begin d.op = OP_ADD;    d.lat = 5'd6;  end
      F_SUB:    begin d.op = OP_SUB;    d.lat = 5'd6;  end
      F_MUL:    begin d.op = OP_MUL;    d.lat = 5'd4;  end
      F_DIV:    begin d.op = OP_DIV;    d.lat = 5'd5;  end
      F_SQRT:   begin d.op = OP_SQRT;   d.lat = 5'd15; end
      F_ABS:    begin d.op = OP_ABS;    d.lat = 5'd1;  end
      F_NEG:    begin d.op = OP_NEG;    d.lat = 5'd1;  end
      F_CEQ:    begin d.op = OP_CEQ;    d.lat = 5'd1;  end
      F_CLT:    begin d.op = OP_CLT;    d.lat = 5'd1;  end
      F_CLE:    begin d.op = OP_CLE;    d.lat = 5'd1;  end
      F_CVTSW:  begin d.op = OP_CVTSW;  d.lat = 5'd5;  end
      F_CVTWS:  begin d.op = OP_CVTWS;  d.lat = 5'd5;  end
      F_ROUNDW: begin d.op = OP_ROUNDW; d.lat = 5'd5;  end
      F_CEILW:  begin d.op = OP_CEILW;  d.lat = 5'd12; end
      F_FLOORW: begin d.op = OP_FLOORW; d.lat = 5'd12; end
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fp_issue_if.sv
// fp_issue_if: issue request/ready plus completion bundle.
// master = requester side, slave = fp_issue_ctrl side.
interface fp_issue_if #(
  parameter int NUM_UNITS = 2,
  parameter int TAG_W     = 5
);
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic             iValid;
  logic             oReady;
  logic [5:0]       iFunct;
  logic [TAG_W-1:0] iTag;
  logic [3:0]       oOp;
  logic             oDoneValid;
  logic [UW-1:0]    oDoneUnit;
  logic [TAG_W-1:0] oDoneTag;
  logic             oIllegal;
  logic [NUM_UNITS-1:0] oBusyMask;

  modport master (
    output iValid, iFunct, iTag,
    input  oReady, oOp, oDoneValid, oDoneUnit,
    input  oDoneTag, oIllegal, oBusyMask
  );

  modport slave (
    input  iValid, iFunct, iTag,
    output oReady, oOp, oDoneValid, oDoneUnit,
    output oDoneTag, oIllegal, oBusyMask
  );
endinterface

// File: rtl/fp_issue_slot.sv
// fp_issue_slot: one execution slot, IDLE -> BUSY(count) -> DONE.
// Ports: clk/rst, flush, alloc+op/lat/tag in, rel (reported), state/op/tag out.
module fp_issue_slot
  import fp_issue_pkg::*;
#(
  parameter int BUSY_W = 5,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc,
  input  logic [3:0]        op_in,
  input  logic [BUSY_W-1:0] lat_in,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic              rel,
  output logic [1:0]        state,
  output logic [3:0]        op,
  output logic [TAG_W-1:0]  tag
);

  logic [BUSY_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op    <= '0;
      tag   <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (alloc) begin
            state <= ST_BUSY;
            cnt   <= lat_in;
            op    <= op_in;
            tag   <= tag_in;
          end
        end
        ST_BUSY: begin
          // last busy cycle: move to DONE on this edge
          if (cnt <= BUSY_W'(1)) state <= ST_DONE;
          cnt <= cnt - BUSY_W'(1);
        end
        ST_DONE: begin
          if (rel) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: FP issue/busy tracker; clk iCLK, async reset iRST, iFlush,
// issue/completion on bus (fp_issue_if.slave); FP_STALL_CNT_EN adds oStallCnt.
module fp_issue_ctrl
  import fp_issue_pkg::*;
#(
  parameter int NUM_UNITS = 2,
  parameter int BUSY_W    = 5,
  parameter int TAG_W     = 5
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFlush,
  fp_issue_if.slave   bus
`ifdef FP_STALL_CNT_EN
  ,
  output logic [31:0] oStallCnt
`endif
);

  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [1:0]       st   [NUM_UNITS];
  logic [3:0]       sop  [NUM_UNITS];
  logic [TAG_W-1:0] stag [NUM_UNITS];

  logic [NUM_UNITS-1:0] busy;
  logic [NUM_UNITS-1:0] alloc_oh;
  logic [NUM_UNITS-1:0] rep_oh;
  logic [UW-1:0]        rep_idx;
  logic                 got;
  logic                 done_any;
  logic                 ready;
  logic                 fire;
  logic                 illegal_q;
  fp_dec_t              dec;

  assign dec   = funct_to_lat(bus.iFunct);
  assign ready = ~&busy;
  // a flush drops any issue in the same cycle
  assign fire  = bus.iValid & ready & ~iFlush;

  always_comb begin
    alloc_oh = '0;
    rep_oh   = '0;
    rep_idx  = '0;
    got      = 1'b0;
    done_any = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (st[i] == ST_IDLE && !got) begin
        alloc_oh[i] = 1'b1;
        got         = 1'b1;
      end
      if (st[i] == ST_DONE && !done_any) begin
        rep_oh[i] = 1'b1;
        rep_idx   = UW'(i);
        done_any  = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_slot
    assign busy[g] = (st[g] != ST_IDLE);
    fp_issue_slot #(
      .BUSY_W (BUSY_W),
      .TAG_W  (TAG_W)
    ) u_slot (
      .clk    (iCLK),
      .rst    (iRST),
      .flush  (iFlush),
      .alloc  (fire & dec.legal & alloc_oh[g]),
      .op_in  (dec.op),
      .lat_in (BUSY_W'(dec.lat)),
      .tag_in (bus.iTag),
      .rel    (rep_oh[g]),
      .state  (st[g]),
      .op     (sop[g]),
      .tag    (stag[g])
    );
  end

  always_comb begin
    bus.oOp      = '0;
    bus.oDoneTag = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (rep_oh[i] && !iFlush) begin
        bus.oOp      = sop[i];
        bus.oDoneTag = stag[i];
      end
    end
  end

  assign bus.oReady     = ready;
  assign bus.oBusyMask  = busy;
  assign bus.oDoneValid = done_any & ~iFlush;
  assign bus.oDoneUnit  = (done_any & ~iFlush) ? rep_idx : '0;
  assign bus.oIllegal   = illegal_q;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) illegal_q <= 1'b0;
    else      illegal_q <= fire & ~dec.legal;
  end

`ifdef FP_STALL_CNT_EN
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)
      oStallCnt <= '0;
    else if (bus.iValid && !ready && oStallCnt != '1)
      oStallCnt <= oStallCnt + 32'd1;
  end
`endif

endmodule
